// File: rtl/sa_drain_pkg.sv
// Shared types and sizing helpers for the systolic-array result drain.
package sa_drain_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int ELEM_W        = 2 * DEFAULT_WIDTH;

  function automatic int elem_width(input int width);
    return 2 * width;
  endfunction

  // A single-row array still needs a 1-bit row index.
  function automatic int row_width(input int vpe);
    return (vpe <= 1) ? 1 : $clog2(vpe);
  endfunction

endpackage

// File: rtl/sa_row_mux.sv
// Selects one array row (HPE accumulator elements) out of the flat snapshot buffer.
module sa_row_mux
  import sa_drain_pkg::*;
#(
  parameter int HPE   = 4,
  parameter int VPE   = 4,
  parameter int WIDTH = 32
) (
  input  logic [elem_width(WIDTH)*HPE*VPE-1:0] buf_i,
  input  logic [row_width(VPE)-1:0]            row_i,
  output logic [elem_width(WIDTH)*HPE-1:0]     row_o
);

  localparam int RW       = row_width(VPE);
  localparam int ROW_BITS = elem_width(WIDTH) * HPE;

  // Explicit compare chain keeps out-of-range indices (non power-of-two VPE) at zero.
  always_comb begin
    row_o = '0;
    for (int v = 0; v < VPE; v++) begin
      if (row_i == RW'(v)) begin
        row_o = buf_i[v*ROW_BITS +: ROW_BITS];
      end
    end
  end

endmodule

// File: rtl/sa_result_drain.sv
// Snapshots the systolic-array result bus on START and streams it out one row per valid/ready beat.
module sa_result_drain
  import sa_drain_pkg::*;
#(
  parameter int HPE   = 4,
  parameter int VPE   = 4,
  parameter int WIDTH = 32
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 START,
  input  logic [elem_width(WIDTH)*HPE*VPE-1:0] YY,
  output logic [elem_width(WIDTH)*HPE-1:0]     OUT_DATA,
  output logic                                 OUT_VALID,
  input  logic                                 OUT_READY,
  output logic [row_width(VPE)-1:0]            OUT_ROW,
  output logic                                 OUT_LAST,
  output logic                                 BUSY,
  output logic                                 DONE,
  output logic                                 dbg_state_o
);

  localparam int RW       = row_width(VPE);
  localparam int BUF_BITS = elem_width(WIDTH) * HPE * VPE;
  localparam logic [RW-1:0] LAST_ROW = RW'(VPE - 1);

  // Handshake: a beat transfers on a rising edge where OUT_VALID and OUT_READY
  // are both high; while OUT_VALID is high and OUT_READY low, data/row/last hold.
  state_t              state_q, state_d;
  logic [BUF_BITS-1:0] buf_q, buf_d;
  logic [RW-1:0]       row_q, row_d;
  logic                done_q, done_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      buf_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    row_d   = row_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          buf_d   = YY;
          row_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (OUT_READY) begin
          if (row_q == LAST_ROW) begin
            row_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  sa_row_mux #(
    .HPE   (HPE),
    .VPE   (VPE),
    .WIDTH (WIDTH)
  ) u_row_mux (
    .buf_i (buf_q),
    .row_i (row_q),
    .row_o (OUT_DATA)
  );

  assign BUSY        = (state_q == SEND);
  assign OUT_VALID   = BUSY;
  assign OUT_ROW     = row_q;
  assign OUT_LAST    = BUSY && (row_q == LAST_ROW);
  assign DONE        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed and scoreboarded bench for sa_result_drain with HPE=VPE=4, WIDTH=8.
module tb_sa_result_drain;

  localparam int HPE = 4;
  localparam int VPE = 4;
  localparam int WIDTH = 8;
  localparam int YW = 2 * WIDTH * HPE * VPE;
  localparam int DW = 2 * WIDTH * HPE;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic [YW-1:0] YY = '0;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
  logic [1:0]    OUT_ROW;
  logic          OUT_LAST;
  logic          BUSY;
  logic          DONE;
  logic          dbg_state;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];

  sa_result_drain #(.HPE(HPE), .VPE(VPE), .WIDTH(WIDTH)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .YY          (YY),
    .OUT_DATA    (OUT_DATA),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .OUT_ROW     (OUT_ROW),
    .OUT_LAST    (OUT_LAST),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge, then let outputs settle before sampling.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [YW-1:0] mk_yy(input logic [15:0] base);
    logic [YW-1:0] y;
    for (int i = 0; i < HPE * VPE; i++) y[i*16 +: 16] = base + 16'(i);
    return y;
  endfunction

  function automatic logic [DW-1:0] row_of(input logic [YW-1:0] y, input int r);
    return y[r*DW +: DW];
  endfunction

  task automatic expect_beat(input string tag, input int r, input logic [DW-1:0] data);
    check({tag, " valid"}, 64'(OUT_VALID), 64'd1);
    check({tag, " busy"},  64'(BUSY),      64'd1);
    check({tag, " row"},   64'(OUT_ROW),   64'(r));
    check({tag, " data"},  OUT_DATA,       data);
    check({tag, " last"},  64'(OUT_LAST),  64'(r == VPE - 1));
    check({tag, " done"},  64'(DONE),      64'd0);
  endtask

  task automatic expect_done(input string tag);
    check({tag, " done"},  64'(DONE),      64'd1);
    check({tag, " valid"}, 64'(OUT_VALID), 64'd0);
    check({tag, " busy"},  64'(BUSY),      64'd0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    START = 1'b0;
    OUT_READY = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    logic [YW-1:0] snap;
    int beats, cyc, done_cnt;

    // 1: reset values, then a full drain with READY held high
    YY = '0;
    do_reset();
    check("rst valid", 64'(OUT_VALID), 64'd0);
    check("rst busy",  64'(BUSY),      64'd0);
    check("rst done",  64'(DONE),      64'd0);
    check("rst last",  64'(OUT_LAST),  64'd0);
    check("rst row",   64'(OUT_ROW),   64'd0);
    check("rst data",  OUT_DATA,       64'd0);
    check("rst state", 64'(dbg_state), 64'd0);

    snap = mk_yy(16'h0100);
    YY = snap;
    START = 1'b1;
    OUT_READY = 1'b1;
    tick();
    START = 1'b0;
    check("t1 row0 lit", OUT_DATA, 64'h0103_0102_0101_0100);
    for (int r = 0; r < VPE; r++) begin
      expect_beat("t1", r, row_of(snap, r));
      if (r == VPE - 1) check("t1 row3 lit", OUT_DATA, 64'h010F_010E_010D_010C);
      tick();
    end
    expect_done("t1");
    tick();
    check("t1 done pulse", 64'(DONE), 64'd0);
    check("t1 idle busy",  64'(BUSY), 64'd0);

    // 2: backpressure during row 1
    snap = mk_yy(16'h0100);
    YY = snap;
    START = 1'b1;
    tick();
    START = 1'b0;
    expect_beat("t2 r0", 0, row_of(snap, 0));
    tick();
    OUT_READY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_beat("t2 stall", 1, row_of(snap, 1));
      tick();
    end
    expect_beat("t2 r1", 1, row_of(snap, 1));
    OUT_READY = 1'b1;
    tick();
    expect_beat("t2 r2", 2, row_of(snap, 2));
    tick();
    expect_beat("t2 r3", 3, row_of(snap, 3));
    tick();
    expect_done("t2");
    tick();

    // 3: YY changes after the snapshot must not leak into the drain
    snap = mk_yy(16'h0100);
    YY = snap;
    START = 1'b1;
    tick();
    START = 1'b0;
    YY = {YW{1'b1}};
    for (int r = 0; r < VPE; r++) begin
      expect_beat("t3", r, row_of(snap, r));
      tick();
    end
    expect_done("t3");
    tick();

    // 4: START held through SEND (incl. final handshake) is ignored; START in DONE cycle is taken
    snap = mk_yy(16'h0100);
    YY = snap;
    START = 1'b1;
    tick();
    YY = mk_yy(16'h0300);
    for (int r = 0; r < VPE; r++) begin
      expect_beat("t4a", r, row_of(snap, r));
      tick();
    end
    expect_done("t4a");
    snap = mk_yy(16'h0200);
    YY = snap;
    tick();
    START = 1'b0;
    for (int r = 0; r < VPE; r++) begin
      expect_beat("t4b", r, row_of(snap, r));
      tick();
    end
    expect_done("t4b");
    tick();

    // 5: reset mid-drain at row 2
    snap = mk_yy(16'h0100);
    YY = snap;
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    tick();
    expect_beat("t5 r2", 2, row_of(snap, 2));
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("t5 valid", 64'(OUT_VALID), 64'd0);
    check("t5 busy",  64'(BUSY),      64'd0);
    check("t5 row",   64'(OUT_ROW),   64'd0);
    check("t5 done",  64'(DONE),      64'd0);
    tick();
    check("t5 done2", 64'(DONE),      64'd0);
    snap = mk_yy(16'h0400);
    YY = snap;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int r = 0; r < VPE; r++) begin
      expect_beat("t5 re", r, row_of(snap, r));
      tick();
    end
    expect_done("t5 re");
    tick();

    // 6: ten back-to-back drains with random READY against the scoreboard
    done_cnt = 0;
    for (int d = 0; d < 10; d++) begin
      for (int w = 0; w < YW / 32; w++) snap[w*32 +: 32] = $urandom;
      YY = snap;
      for (int r = 0; r < VPE; r++) exp_q.push_back(row_of(snap, r));
      START = 1'b1;
      OUT_READY = 1'($urandom_range(0, 1));
      tick();
      START = 1'b0;
      YY = ~snap;
      beats = 0;
      cyc = 0;
      while (beats < VPE && cyc < 200) begin
        check("t6 valid", 64'(OUT_VALID), 64'd1);
        check("t6 done",  64'(DONE),      64'd0);
        OUT_READY = 1'($urandom_range(0, 1));
        if (OUT_VALID && OUT_READY) begin
          check("t6 row",  64'(OUT_ROW),  64'(beats));
          check("t6 last", 64'(OUT_LAST), 64'(beats == VPE - 1));
          if (exp_q.size() > 0) check("t6 data", OUT_DATA, exp_q.pop_front());
          else check("t6 underflow", 64'd1, 64'd0);
          beats++;
        end
        tick();
        cyc++;
      end
      check("t6 beats", 64'(beats), 64'(VPE));
      check("t6 done pulse", 64'(DONE), 64'd1);
      if (DONE) done_cnt++;
    end
    OUT_READY = 1'b1;
    tick();
    check("t6 done after", 64'(DONE), 64'd0);
    check("t6 done count", 64'(done_cnt), 64'd10);
    check("t6 queue empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
